pattern_scan_ctrl: RTL and testbench

//  Sequencer wrapped around a serial "101" Moore detector (states A/B/C/D, z=1 in D, overlapping).

---
 rtl/pattern_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_pattern_scan_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl
//   Takes W-bit words over a valid/ready handshake, shifts each one MSB-first
//   through an overlapping "101" Moore detector, and returns the number of
//   detector entries into state D over a second valid/ready handshake.
//   Optional build macro: PATTERN_POS_EN adds out_first_pos, which gives the
//   bit index of the first completed match.
module pattern_scan_ctrl #(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1),
    localparam int PW = $clog2(W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic          out_hit,
    output logic          busy
`ifdef PATTERN_POS_EN
    ,
    output logic [PW-1:0] out_first_pos
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} ctl_t;
    typedef enum logic [1:0] {DET_A, DET_B, DET_C, DET_D} det_t;

    ctl_t          ctl;
    det_t          det;
    det_t          det_next;
    logic [W-1:0]  shreg;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [PW-1:0] idx;
    logic          hit;
`ifdef PATTERN_POS_EN
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_next;
`endif

    // Next detector state for the bit at the head of the shift register, and
    // the hit count and first-match index that result from consuming it.
    always_comb begin
        // NOTE: every combinational output is given a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        det_next = det;
        unique case (det)
            DET_A: det_next = shreg[W-1] ? DET_B : DET_A;
            DET_B: det_next = shreg[W-1] ? DET_B : DET_C;
            DET_C: det_next = shreg[W-1] ? DET_D : DET_A;
            DET_D: det_next = shreg[W-1] ? DET_B : DET_C;
        endcase
        hit      = (det_next == DET_D);
        cnt_next = cnt + CW'(hit);
`ifdef PATTERN_POS_EN
        pos_next = (hit && (cnt == '0)) ? idx : pos;
`endif
    end

    // Controller FSM: accept a word, shift it W cycles, then hold the result
    // until the consumer takes it. All handshake outputs are registered.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every reader
        // in this clock edge sees the pre-edge value, independent of order.
        if (rst) begin
            ctl       <= IDLE;
            det       <= DET_A;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_count <= '0;
            out_hit   <= 1'b0;
            busy      <= 1'b0;
`ifdef PATTERN_POS_EN
            pos           <= '0;
            out_first_pos <= '0;
`endif
        end else begin
            case (ctl)
                IDLE: begin
                    if (in_valid) begin
                        shreg    <= in_data;
                        det      <= DET_A;
                        cnt      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        ctl      <= SHIFT;
`ifdef PATTERN_POS_EN
                        pos      <= '0;
`endif
                    end
                end
                SHIFT: begin
                    shreg <= shreg << 1;
                    det   <= det_next;
                    cnt   <= cnt_next;
                    idx   <= idx + PW'(1);
`ifdef PATTERN_POS_EN
                    pos   <= pos_next;
`endif
                    if (idx == PW'(W - 1)) begin
                        // Last bit: publish the result including this bit's hit.
                        ctl       <= DONE;
                        out_valid <= 1'b1;
                        out_count <= cnt_next;
                        out_hit   <= (cnt_next != '0);
`ifdef PATTERN_POS_EN
                        out_first_pos <= pos_next;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        ctl       <= IDLE;
                    end
                end
                default: begin
                    ctl       <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl
//   Directed bench for pattern_scan_ctrl (W=8). Inputs change and outputs are
//   sampled on the falling clock edge; expected values are worked out by hand
//   from the "101" detector transitions. Define PATTERN_POS_EN to also check
//   out_first_pos.
module tb_pattern_scan_ctrl;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);
    localparam int PW = $clog2(W);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_count;
    logic          out_hit;
    logic          busy;
`ifdef PATTERN_POS_EN
    logic [PW-1:0] out_first_pos;
`endif

    int n_cmp = 0;
    int n_err = 0;

    pattern_scan_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_hit   (out_hit),
        .busy      (busy)
`ifdef PATTERN_POS_EN
        ,
        .out_first_pos (out_first_pos)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One word with out_ready held high: accept at edge 0, result after edge W,
    // transfer at edge W+1.
    task automatic run_word(input string tag, input logic [W-1:0] data, input int exp_cnt);
        in_data   = data;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = ~data;
        check({tag, ".in_ready_after_accept"}, 32'(in_ready), 32'd0);
        check({tag, ".busy_after_accept"}, 32'(busy), 32'd1);
        repeat (W - 1) @(negedge clk);
        check({tag, ".out_valid_before_edge_w"}, 32'(out_valid), 32'd0);
        @(negedge clk);
        check({tag, ".out_valid_at_edge_w"}, 32'(out_valid), 32'd1);
        check({tag, ".out_count"}, 32'(out_count), 32'(exp_cnt));
        check({tag, ".out_hit"}, 32'(out_hit), 32'(exp_cnt != 0));
        @(negedge clk);
        check({tag, ".in_ready_after_transfer"}, 32'(in_ready), 32'd1);
        check({tag, ".out_valid_after_transfer"}, 32'(out_valid), 32'd0);
        check({tag, ".busy_after_transfer"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held across two rising edges.
        repeat (2) @(negedge clk);
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.out_count", 32'(out_count), 32'd0);
        check("reset.out_hit", 32'(out_hit), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.in_ready", 32'(in_ready), 32'd1);

        // 1,0,1,0,0,1,0,1 : B C D C A B C D -> 2 hits, first at idx 2.
        run_word("w_a5", 8'b1010_0101, 2);
`ifdef PATTERN_POS_EN
        check("w_a5.first_pos", 32'(out_first_pos), 32'd2);
`endif

        // All ones: stays in B -> no hits.
        run_word("w_ff", 8'hFF, 0);
`ifdef PATTERN_POS_EN
        check("w_ff.first_pos", 32'(out_first_pos), 32'd0);
`endif

        // 1,0,1,0,1,1,0,1 : B C D C D B C D -> 3 hits (overlap), first at idx 2.
        run_word("w_ad", 8'b1010_1101, 3);
`ifdef PATTERN_POS_EN
        check("w_ad.first_pos", 32'(out_first_pos), 32'd2);
`endif

        // 0,1,0,1,0,1,0,1 : A B C D C D C D -> 3 hits, first at idx 3.
        run_word("w_55", 8'b0101_0101, 3);
`ifdef PATTERN_POS_EN
        check("w_55.first_pos", 32'(out_first_pos), 32'd3);
`endif

        // Single 1 in the MSB: B then C, A, A... -> no hits.
        run_word("w_80", 8'b1000_0000, 0);

        // Back-pressure: out_ready low for 5 cycles in DONE, new word offered.
        in_data   = 8'b1010_0101;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_data = 8'hFF;
        repeat (W) @(negedge clk);
        check("stall.out_valid_enter", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall.out_valid_%0d", i), 32'(out_valid), 32'd1);
            check($sformatf("stall.out_count_%0d", i), 32'(out_count), 32'd2);
            check($sformatf("stall.in_ready_%0d", i), 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("stall.out_valid_release", 32'(out_valid), 32'd0);
        check("stall.in_ready_release", 32'(in_ready), 32'd1);
        check("stall.out_count_held", 32'(out_count), 32'd2);

        // Abort mid-SHIFT: reset sampled at edge 4 after accept.
        in_data  = 8'b1010_1101;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort.in_ready", 32'(in_ready), 32'd1);
        check("abort.out_valid", 32'(out_valid), 32'd0);
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.out_count", 32'(out_count), 32'd0);
        // No result may appear for the abandoned word.
        repeat (W) @(negedge clk);
        check("abort.no_result", 32'(out_valid), 32'd0);

        // 0,0,0,0,0,1,0,1 : A A A A A B C D -> 1 hit at the last bit (idx 7).
        run_word("post_abort", 8'b0000_0101, 1);
`ifdef PATTERN_POS_EN
        check("post_abort.first_pos", 32'(out_first_pos), 32'd7);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
